// File: rtl/par2ser_bitstream.sv
// par2ser_bitstream: parallel-to-serial front end for the serial sequence
// detector. Words arrive over valid/ready into a one-deep holding register.
// They are then shifted out one bit per bit_en tick. The idle level is
// driven whenever no word is in flight.
module par2ser_bitstream #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             cur_bit;
  logic [WIDTH-1:0] shifted;

  // Pick the output end of the shifter and form the next shifted value.
  // The vacated end is zero-filled.
  always_comb begin
    accept = din_valid && !hold_full;
    if (MSB_FIRST) begin
      cur_bit = shreg[WIDTH-1];
      shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      cur_bit = shreg[0];
      shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign din_ready = !hold_full;
  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid ? cur_bit : IDLE_BIT;
  assign busy      = ser_valid | hold_full;

  // Handshake capture, the word-load/shift FSM and the word_done pulse.
  // An accept only happens when hold is empty.
  // A load only happens when hold is full.
  // The two never fight over hold_full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (accept) begin
        hold      <= din;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hold_full) begin
            shreg     <= hold;
            cnt       <= '0;
            hold_full <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            if (cnt == LAST) begin
              word_done <= 1'b1;
              if (hold_full) begin
                shreg     <= hold;
                cnt       <= '0;
                hold_full <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              shreg <= shifted;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
